// File: rtl/conv_window_fetch.sv
// conv_window_fetch: raster-scans the image, fetches each zero-padded 3x3
// neighbourhood from a 1-cycle-latency memory, presents it to the
// convolution stage and waits for its finish before moving on.
module conv_window_fetch #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [19:0]   idata,
  output logic [179:0]  pixel,
  output logic          start,
  input  logic          finish,
  output logic [AW-1:0] cur_addr,
  output logic          done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = AW - XW;

  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [3:0]      r_t;
  logic            r_padCur;
  logic            r_padDly;
  logic [AW-1:0]   r_iaddr;
  logic [179:0]    r_pixel;
  logic            w_lastWin;
  logic            w_xWrap;
  logic [XW-1:0]   w_nx;
  logic [YW-1:0]   w_ny;

  // Tap t of the window centred on (x, y): returns {pad, address}.
  // Row/column are evaluated as signed integers so that -1 and the
  // one-past-the-edge value are both detected as padding (no wrap).
  function automatic logic [AW:0] tapAddr(input logic [XW-1:0] x,
                                          input logic [YW-1:0] y,
                                          input int t);
    int row;
    int col;
    row = int'(y) + (t / 3) - 1;
    col = int'(x) + (t % 3) - 1;
    if ((row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W))
      return {1'b1, {AW{1'b0}}};
    else
      return {1'b0, AW'(row * IMG_W + col)};
  endfunction

  assign w_xWrap   = (r_x == XW'(IMG_W - 1));
  assign w_lastWin = w_xWrap && (r_y == YW'(IMG_H - 1));
  assign w_nx      = w_xWrap ? '0 : r_x + XW'(1);
  assign w_ny      = w_xWrap ? r_y + YW'(1) : r_y;

  assign busy     = (r_state != IDLE);
  assign start    = (r_state == START);
  assign done     = (r_state == DONE);
  assign iaddr    = r_iaddr;
  assign pixel    = r_pixel;
  assign cur_addr = {r_y, r_x};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; finish only matters in WAIT, ready only in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ready) w_next = FETCH;
      FETCH:   if (r_t == 4'd9) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (finish) w_next = w_lastWin ? DONE : FETCH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: the address register always holds the tap whose data will
  // return next cycle, so it is preloaded with tap 0 on entry to FETCH and
  // stays frozen while the window is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_t      <= '0;
      r_padCur <= 1'b0;
      r_padDly <= 1'b0;
      r_iaddr  <= '0;
      r_pixel  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ready) begin
            r_x <= '0;
            r_y <= '0;
            r_t <= '0;
            {r_padCur, r_iaddr} <= tapAddr(XW'(0), YW'(0), 0);
          end
        end
        FETCH: begin
          r_t      <= r_t + 4'd1;
          r_padDly <= r_padCur;
          if (r_t <= 4'd7)
            {r_padCur, r_iaddr} <= tapAddr(r_x, r_y, int'(r_t) + 1);
          if (r_t != 4'd0)
            r_pixel[179 - 20 * (int'(r_t) - 1) -: 20] <= r_padDly ? 20'd0 : idata;
        end
        WAIT: begin
          if (finish) begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_t <= '0;
            if (!w_lastWin)
              {r_padCur, r_iaddr} <= tapAddr(w_nx, w_ny, 0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Self-checking bench for conv_window_fetch: an image memory holding
// mem[a] = a, a convolution-stage stand-in driven from the test tasks, and
// a scoreboard of expected windows pushed whenever the bench starts a frame
// or returns a finish.
module tb_conv_window_fetch;

  logic         clk;
  logic         reset;
  logic         ready;
  logic         busy;
  logic [11:0]  iaddr;
  logic [19:0]  idata;
  logic [179:0] pixel;
  logic         start;
  logic         finish;
  logic [11:0]  cur_addr;
  logic         done;

  logic [19:0] mem [0:4095];

  typedef struct {
    logic [11:0]  addr;
    logic [179:0] pix;
  } exp_t;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;
  int   mX;
  int   mY;

  conv_window_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .pixel    (pixel),
    .start    (start),
    .finish   (finish),
    .cur_addr (cur_addr),
    .done     (done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read image memory with one cycle of latency.
  always @(posedge clk) idata <= mem[iaddr];

  // Expected window for output position (x, y) given mem[a] = a.
  function automatic logic [179:0] expWindow(input int x, input int y);
    logic [179:0] w;
    int r;
    int c;
    int v;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      r = y + k / 3 - 1;
      c = x + k % 3 - 1;
      v = (r < 0 || r > 63 || c < 0 || c > 63) ? 0 : r * 64 + c;
      w[179 - 20 * k -: 20] = 20'(v);
    end
    return w;
  endfunction

  // Record the window the DUT should present next.
  function automatic void pushWindow(input int x, input int y);
    exp_t e;
    e.addr = 12'(y * 64 + x);
    e.pix  = expWindow(x, y);
    sbQueue.push_back(e);
  endfunction

  // Check every output against its reset value (called while reset is high).
  task automatic checkResetValues(input string tag);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy got %b want 0", tag, busy); end
    checks++;
    if (start !== 1'b0) begin errors++; $display("[TB] FAIL %s_start got %b want 0", tag, start); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done got %b want 0", tag, done); end
    checks++;
    if (pixel !== 180'd0) begin errors++; $display("[TB] FAIL %s_pixel got %h want 0", tag, pixel); end
    checks++;
    if (iaddr !== 12'd0) begin errors++; $display("[TB] FAIL %s_iaddr got %0d want 0", tag, iaddr); end
    checks++;
    if (cur_addr !== 12'd0) begin errors++; $display("[TB] FAIL %s_cur_addr got %0d want 0", tag, cur_addr); end
  endtask

  // Pulse ready for one cycle (called at a falling edge) and expect busy.
  task automatic startFrame();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_before_ready got %b want 0", busy); end
    mX = 0;
    mY = 0;
    pushWindow(0, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_ready got %b want 1", busy); end
  endtask

  // Wait for the next start, compare it against the scoreboard, hold the
  // window for d cycles while checking stability, then return finish.
  // Returns at the falling edge after the finish edge.
  task automatic serviceWindow(input int d, input bit finAtStart);
    bit           seen;
    bit           stable;
    exp_t         e;
    logic [179:0] hp;
    logic [11:0]  ha;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL start_timeout window %0d got no start want start", mY * 64 + mX);
      return;
    end
    checks++;
    if (sbQueue.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_start got start at cur_addr %0d want none", cur_addr);
    end else begin
      e = sbQueue.pop_front();
      checks++;
      if (pixel !== e.pix) begin
        errors++;
        $display("[TB] FAIL pixel_w%0d got %h want %h", e.addr, pixel, e.pix);
      end
      checks++;
      if (cur_addr !== e.addr) begin
        errors++;
        $display("[TB] FAIL cur_addr got %0d want %0d", cur_addr, e.addr);
      end
    end
    hp = pixel;
    ha = cur_addr;
    stable = 1'b1;
    if (finAtStart) finish = 1'b1;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      finish = 1'b0;
      if (start !== 1'b0 || pixel !== hp || cur_addr !== ha || done !== 1'b0) stable = 1'b0;
      if (k == d) finish = 1'b1;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL hold_w%0d got changed/restarted window want stable", ha);
    end
    if (!(mX == 63 && mY == 63)) begin
      if (mX == 63) begin
        mX = 0;
        mY = mY + 1;
      end else begin
        mX = mX + 1;
      end
      pushWindow(mX, mY);
    end
    @(negedge clk);
    finish = 1'b0;
  endtask

  // Asynchronous reset with no clock edge must clear outputs at once.
  task automatic test_reset();
    reset  = 1'b0;
    ready  = 1'b0;
    finish = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Top-left window; a finish coincident with start must be ignored and a
  // 40-cycle finish delay must leave the window untouched.
  task automatic test_corner();
    startFrame();
    serviceWindow(40, 1'b1);
  endtask

  // A finish pulse while the next window is being fetched must not advance
  // the scan.
  task automatic test_spurious_finish();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    serviceWindow(1, 1'b0);
  endtask

  // Run to window (1,1) and watch its nine read addresses.
  task automatic test_interior();
    logic [11:0] expA [9];
    expA = '{12'd0, 12'd1, 12'd2, 12'd64, 12'd65, 12'd66, 12'd128, 12'd129, 12'd130};
    while (mY * 64 + mX != 65) serviceWindow(1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k != 0) @(negedge clk);
      checks++;
      if (iaddr !== expA[k]) begin
        errors++;
        $display("[TB] FAIL iaddr_tap%0d got %0d want %0d", k, iaddr, expA[k]);
      end
    end
    serviceWindow(11, 1'b0);
  endtask

  // Finish the frame with ready held high, then check the end-of-frame
  // done/busy sequence and that nothing restarts.
  task automatic test_bottom_right();
    bit quiet;
    ready = 1'b1;
    while (!(mX == 63 && mY == 63)) serviceWindow(1, 1'b0);
    ready = 1'b0;
    serviceWindow(1, 1'b0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse got %b want 1", done); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_at_done got %b want 1", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_width got %b want 0", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_done got %b want 0", busy); end
    quiet = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (start !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("[TB] FAIL idle_after_frame got activity want idle"); end
  endtask

  // Reset during the fetch of window 10, then a fresh frame from the corner.
  task automatic test_reset_midop();
    startFrame();
    while (mY * 64 + mX != 10) serviceWindow(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 checkResetValues("midop");
    sbQueue.delete();
    @(negedge clk);
    reset = 1'b0;
    startFrame();
    serviceWindow(11, 1'b0);
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 20'(i);
    test_reset();
    test_corner();
    test_spurious_finish();
    test_interior();
    test_bottom_right();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
